mipi_dphy_tx_lane_sequencer: RTL and testbench

MIPI_DPHY_TX_LANE_SEQUENCER -- requirements
Module: mipi_dphy_tx_lane_sequencer

---
 rtl/mipi_dphy_tx_pkg.sv | 24 ++
 rtl/mipi_dphy_tx_timer.sv | 27 ++
 rtl/mipi_dphy_tx_lane_sequencer.sv | 147 ++++++++++++++
 tb/tb_mipi_dphy_tx_lane_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_dphy_tx_pkg.sv
// Shared types and constants for the MIPI D-PHY TX lane sequencer.
// Holds the FSM state encoding, the HS sync byte and default timings.
package mipi_dphy_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LP01,
    ST_LP00,
    ST_HS_ZERO,
    ST_SYNC,
    ST_DATA,
    ST_TRAIL,
    ST_EXIT
  } state_t;

  localparam int         CNT_W           = 8;
  localparam logic [7:0] SYNC_BYTE       = 8'hB8;
  localparam logic [7:0] DEF_LPX_CYC     = 8'd4;
  localparam logic [7:0] DEF_PREPARE_CYC = 8'd4;
  localparam logic [7:0] DEF_ZERO_CYC    = 8'd16;
  localparam logic [7:0] DEF_TRAIL_CYC   = 8'd6;
  localparam logic [7:0] DEF_EXIT_CYC    = 8'd8;

endpackage

// File: rtl/mipi_dphy_tx_timer.sv
// Loadable down-counter that times every sequencer state.
// Holds at zero until reloaded; O_zero flags the final cycle.
module mipi_dphy_tx_timer
  import mipi_dphy_tx_pkg::*;
(
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_load,
  input  logic [CNT_W-1:0] I_load_val,
  output logic             O_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_cnt <= '0;
    end else if (I_load) begin
      r_cnt <= I_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign O_zero = (r_cnt == '0);

endmodule

// File: rtl/mipi_dphy_tx_lane_sequencer.sv
// D-PHY TX data-lane sequencer: LP-11 -> SoT -> HS burst -> trail -> LP-11.
// Line outputs are a registered image of the FSM, one cycle behind it.
module mipi_dphy_tx_lane_sequencer
  import mipi_dphy_tx_pkg::*;
#(
  parameter int         LANE_NUM    = 4,
  parameter logic [7:0] LPX_CYC     = DEF_LPX_CYC,
  parameter logic [7:0] PREPARE_CYC = DEF_PREPARE_CYC,
  parameter logic [7:0] ZERO_CYC    = DEF_ZERO_CYC,
  parameter logic [7:0] TRAIL_CYC   = DEF_TRAIL_CYC,
  parameter logic [7:0] EXIT_CYC    = DEF_EXIT_CYC
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_hs_tx_valid,
  input  logic [8*LANE_NUM-1:0] I_hs_tx_data,
  input  logic                  I_hs_tx_last,
  output logic                  O_hs_tx_ready,
  output logic                  O_hs_en,
  output logic                  O_lp_dp,
  output logic                  O_lp_dn,
  output logic [8*LANE_NUM-1:0] O_lane_data,
  output logic                  O_busy,
  output logic                  O_underflow
);

  localparam int DW = 8 * LANE_NUM;

  state_t          r_state;
  logic            r_hs_en;
  logic            r_lp_dp;
  logic            r_lp_dn;
  logic [DW-1:0]   r_lane_data;
  logic [DW-1:0]   r_trail;
  logic [DW-1:0]   w_trail_src;
  logic [DW-1:0]   w_trail;
  logic            w_zero;
  logic            w_adv;
  logic            w_in_data;
  logic [CNT_W-1:0] w_load_val;

  mipi_dphy_tx_timer u_timer (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_load     (w_adv),
    .I_load_val (w_load_val),
    .O_zero     (w_zero)
  );

  assign w_in_data     = (r_state == ST_DATA);
  assign O_hs_tx_ready = w_in_data;
  assign O_busy        = (r_state != ST_IDLE);
  assign O_underflow   = w_in_data && !I_hs_tx_valid;

  assign O_hs_en     = r_hs_en;
  assign O_lp_dp     = r_lp_dp;
  assign O_lp_dn     = r_lp_dn;
  assign O_lane_data = r_lane_data;

  // On starvation the trail follows the byte already on the wire.
  assign w_trail_src = I_hs_tx_valid ? I_hs_tx_data : r_lane_data;

  always_comb begin
    w_trail = '0;
    for (int n = 0; n < LANE_NUM; n++) begin
      w_trail[8*n +: 8] = {8{~w_trail_src[8*n+7]}};
    end
  end

  always_comb begin
    w_adv      = w_zero;
    w_load_val = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_adv      = I_hs_tx_valid;
        w_load_val = LPX_CYC - 8'd1;
      end
      ST_LP01:    w_load_val = PREPARE_CYC - 8'd1;
      ST_LP00:    w_load_val = ZERO_CYC - 8'd1;
      ST_DATA: begin
        w_adv      = !I_hs_tx_valid || I_hs_tx_last;
        w_load_val = TRAIL_CYC - 8'd1;
      end
      ST_TRAIL:   w_load_val = EXIT_CYC - 8'd1;
      default:    w_load_val = '0;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state     <= ST_IDLE;
      r_hs_en     <= 1'b0;
      r_lp_dp     <= 1'b1;
      r_lp_dn     <= 1'b1;
      r_lane_data <= '0;
      r_trail     <= '0;
    end else begin
      r_hs_en     <= 1'b0;
      r_lp_dp     <= 1'b0;
      r_lp_dn     <= 1'b0;
      r_lane_data <= '0;
      unique case (r_state)
        ST_IDLE: begin
          r_lp_dp <= 1'b1;
          r_lp_dn <= 1'b1;
          if (w_adv) r_state <= ST_LP01;
        end
        ST_LP01: begin
          r_lp_dn <= 1'b1;
          if (w_adv) r_state <= ST_LP00;
        end
        ST_LP00: begin
          if (w_adv) r_state <= ST_HS_ZERO;
        end
        ST_HS_ZERO: begin
          r_hs_en <= 1'b1;
          if (w_adv) r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          r_hs_en     <= 1'b1;
          r_lane_data <= {LANE_NUM{SYNC_BYTE}};
          if (w_adv) r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_hs_en     <= 1'b1;
          r_lane_data <= I_hs_tx_valid ? I_hs_tx_data : w_trail;
          if (w_adv) begin
            r_trail <= w_trail;
            r_state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          r_hs_en     <= 1'b1;
          r_lane_data <= r_trail;
          if (w_adv) r_state <= ST_EXIT;
        end
        ST_EXIT: begin
          r_lp_dp <= 1'b1;
          r_lp_dn <= 1'b1;
          if (w_adv) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_dphy_tx_lane_sequencer.sv
// Bench for the D-PHY TX lane sequencer: default and all-ones timing.
// Expected line activity is built as a per-cycle sequence from phase lengths.
module tb_mipi_dphy_tx_lane_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic [31:0] data = '0;

  logic        rdy0, hs0, dp0, dn0, busy0, uf0;
  logic [31:0] ld0;
  logic        rdy1, hs1, dp1, dn1, busy1, uf1;
  logic [31:0] ld1;

  int          sel = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] words [16];
  logic [37:0] act;

  always #5 clk = ~clk;

  mipi_dphy_tx_lane_sequencer dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_hs_tx_valid (valid),
    .I_hs_tx_data  (data),
    .I_hs_tx_last  (last),
    .O_hs_tx_ready (rdy0),
    .O_hs_en       (hs0),
    .O_lp_dp       (dp0),
    .O_lp_dn       (dn0),
    .O_lane_data   (ld0),
    .O_busy        (busy0),
    .O_underflow   (uf0)
  );

  mipi_dphy_tx_lane_sequencer #(
    .LANE_NUM    (4),
    .LPX_CYC     (8'd1),
    .PREPARE_CYC (8'd1),
    .ZERO_CYC    (8'd1),
    .TRAIL_CYC   (8'd1),
    .EXIT_CYC    (8'd1)
  ) dut1 (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_hs_tx_valid (valid),
    .I_hs_tx_data  (data),
    .I_hs_tx_last  (last),
    .O_hs_tx_ready (rdy1),
    .O_hs_en       (hs1),
    .O_lp_dp       (dp1),
    .O_lp_dn       (dn1),
    .O_lane_data   (ld1),
    .O_busy        (busy1),
    .O_underflow   (uf1)
  );

  // {busy, ready, underflow, hs_en, dp, dn, lane_data}
  always_comb begin
    if (sel != 0) act = {busy1, rdy1, uf1, hs1, dp1, dn1, ld1};
    else          act = {busy0, rdy0, uf0, hs0, dp0, dn0, ld0};
  end

  function automatic logic [31:0] trail_of(input logic [31:0] w);
    logic [31:0] t;
    for (int n = 0; n < 4; n++) begin
      t[8*n +: 8] = w[8*n+7] ? 8'h00 : 8'hFF;
    end
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // k >= 0 and k < n: valid drops when word k is due (underflow).
  // hold: valid stays high after the words run out, until the final idle cycle.
  task automatic run_burst(input int n, input int k, input bit hold,
                           output int nbusy, output int nuf,
                           output logic [31:0] trl);
    int L, P, Z, T, E, acc, t0, idx, len;
    bit u, v;
    logic [31:0] lb, tw;
    logic [2:0]  st [$];
    logic [34:0] ln [$];
    L = (sel != 0) ? 1 : 4;
    P = (sel != 0) ? 1 : 4;
    Z = (sel != 0) ? 1 : 16;
    T = (sel != 0) ? 1 : 6;
    E = (sel != 0) ? 1 : 8;
    u = (k >= 0) && (k < n);
    acc = u ? k : n;
    lb = (acc == 0) ? 32'hB8B8_B8B8 : words[acc-1];
    tw = trail_of(lb);
    st.push_back(3'b000);
    repeat (L + P + Z + 1) st.push_back(3'b100);
    repeat (acc) st.push_back(3'b110);
    if (u) st.push_back(3'b111);
    repeat (T + E) st.push_back(3'b100);
    st.push_back(3'b000);
    ln.push_back({3'b011, 32'h0});
    ln.push_back({3'b011, 32'h0});
    repeat (L) ln.push_back({3'b001, 32'h0});
    repeat (P) ln.push_back({3'b000, 32'h0});
    repeat (Z) ln.push_back({3'b100, 32'h0});
    ln.push_back({3'b100, 32'hB8B8_B8B8});
    for (int i = 0; i < acc; i++) ln.push_back({3'b100, words[i]});
    repeat (T + (u ? 1 : 0)) ln.push_back({3'b100, tw});
    repeat (E) ln.push_back({3'b011, 32'h0});
    len = st.size();
    t0 = L + P + Z + 2;
    idx = 0;
    nbusy = 0;
    nuf = 0;
    trl = '0;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      v = (t < len - 1) && (hold || idx < n);
      if (u && t >= t0 + k && !(hold && t > t0 + k)) v = 1'b0;
      valid = v;
      data = (idx < n) ? words[idx] : $urandom;
      last = (idx == n - 1);
      #1;
      n_chk++;
      if (act !== {st[t], ln[t]}) begin
        n_fail++;
        $display("FAIL trace sel=%0d t=%0d got=%h exp=%h",
                 sel, t, act, {st[t], ln[t]});
      end
      if (act[37]) nbusy++;
      if (act[35]) nuf++;
      if (t == t0 + acc + 1) trl = act[31:0];
      if (v && act[36]) idx++;
    end
    valid = 1'b0;
    last = 1'b0;
    n_chk++;
    if (idx != acc) begin
      n_fail++;
      $display("FAIL consumed got=%0d exp=%0d", idx, acc);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      n_chk++;
      if (act !== {6'b000011, 32'h0}) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d got=%h exp=%h",
                 s, act, {6'b000011, 32'h0});
      end
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_burst();
    int nb, nu;
    logic [31:0] tr;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_burst(3, -1, 1'b0, nb, nu, tr);
    n_chk++;
    if (nb != 42) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got=%0d exp=42", nb);
    end
  endtask

  task automatic test_trail_polarity();
    int nb, nu;
    logic [31:0] tr;
    words[0] = 32'h80FF_7F01;
    words[1] = 32'h0000_0080;
    run_burst(2, -1, 1'b0, nb, nu, tr);
    n_chk++;
    if (tr !== 32'hFFFF_FF00) begin
      n_fail++;
      $display("FAIL trail_bytes got=%h exp=%h", tr, 32'hFFFF_FF00);
    end
  endtask

  task automatic test_underflow();
    int nb, nu;
    logic [31:0] tr;
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    run_burst(5, 2, 1'b0, nb, nu, tr);
    n_chk++;
    if (nu != 1) begin
      n_fail++;
      $display("FAIL underflow_pulses got=%0d exp=1", nu);
    end
    run_burst(3, 0, 1'b0, nb, nu, tr);
    n_chk++;
    if (tr !== 32'h0) begin
      n_fail++;
      $display("FAIL underflow_first_trail got=%h exp=0", tr);
    end
  endtask

  task automatic test_valid_held();
    int nb, nu;
    logic [31:0] tr;
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    run_burst(4, -1, 1'b1, nb, nu, tr);
  endtask

  task automatic test_reset_mid_burst();
    int nb, nu;
    logic [31:0] tr;
    @(negedge clk);
    valid = 1'b1;
    data = $urandom;
    last = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    n_chk++;
    if (act[34] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_hs_en got=%b exp=1", act[34]);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (act !== {6'b000011, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_state got=%h exp=%h",
               act, {6'b000011, 32'h0});
    end
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    run_burst(2, -1, 1'b0, nb, nu, tr);
    n_chk++;
    if (nb != 41) begin
      n_fail++;
      $display("FAIL replay_busy_cycles got=%0d exp=41", nb);
    end
  endtask

  task automatic test_min_timing();
    int nb, nu;
    logic [31:0] tr;
    do_reset();
    sel = 1;
    words[0] = $urandom;
    run_burst(1, -1, 1'b0, nb, nu, tr);
    n_chk++;
    if (nb != 7) begin
      n_fail++;
      $display("FAIL min_timing_busy got=%0d exp=7", nb);
    end
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    run_burst(4, 1, 1'b1, nb, nu, tr);
    do_reset();
    sel = 0;
  endtask

  task automatic test_back_to_back();
    int nb, nu, n, k;
    logic [31:0] tr;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      k = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_burst(n, k, 1'($urandom_range(0, 1)), nb, nu, tr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_trail_polarity();
    test_underflow();
    test_valid_held();
    test_reset_mid_burst();
    test_min_timing();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
